// File: rtl/tone_note_player.sv
// Plays an (octave, note) pair as a square wave: a 12-entry base-divider ROM sets the pitch,
// and an octave counter stretches each half-period by 256 >> octave.
module tone_note_player #(
  parameter int NOTE_DIV_W = 10,
  parameter int OCT_CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_octave,
  input  logic [3:0] in_note,
  input  logic       stop,
  output logic [5:0] note_index,
  output logic       playing,
  output logic       err,
  output logic       speaker
);

  // state | meaning
  // IDLE  | silent, waiting for a note
  // LOAD  | one cycle: build note index and preload the dividers
  // PLAY  | dividers running, speaker toggling every half-period
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t                  state_q;
  logic [2:0]              oct_q;
  logic [3:0]              note_q;
  logic [5:0]              note_index_q;
  logic [NOTE_DIV_W-1:0]   cnt_note_q;
  logic [OCT_CNT_W-1:0]    cnt_oct_q;
  logic [OCT_CNT_W-1:0]    oct_reload_q;
  logic                    speaker_q;
  logic                    playing_q;
  logic                    err_q;

  logic [6:0]              in_index;
  logic [6:0]              cap_index;
  logic                    in_legal;
  logic                    xfer;
  logic [NOTE_DIV_W-1:0]   rom_div;
  logic [OCT_CNT_W-1:0]    oct_max;
  logic [OCT_CNT_W-1:0]    oct_reload_d;

  function automatic logic [NOTE_DIV_W-1:0] rom_lookup(input logic [3:0] n);
    case (n)
      4'd0:    rom_lookup = NOTE_DIV_W'(512);
      4'd1:    rom_lookup = NOTE_DIV_W'(483);
      4'd2:    rom_lookup = NOTE_DIV_W'(456);
      4'd3:    rom_lookup = NOTE_DIV_W'(431);
      4'd4:    rom_lookup = NOTE_DIV_W'(406);
      4'd5:    rom_lookup = NOTE_DIV_W'(384);
      4'd6:    rom_lookup = NOTE_DIV_W'(362);
      4'd7:    rom_lookup = NOTE_DIV_W'(342);
      4'd8:    rom_lookup = NOTE_DIV_W'(323);
      4'd9:    rom_lookup = NOTE_DIV_W'(304);
      4'd10:   rom_lookup = NOTE_DIV_W'(287);
      4'd11:   rom_lookup = NOTE_DIV_W'(271);
      default: rom_lookup = '0;
    endcase
  endfunction

  // octave*12 as (oct<<3)+(oct<<2); 7 bits so octave 7 + note 15 cannot wrap
  assign in_index  = {1'b0, in_octave, 3'b000} + {2'b00, in_octave, 2'b00} + {3'b000, in_note};
  assign cap_index = {1'b0, oct_q, 3'b000} + {2'b00, oct_q, 2'b00} + {3'b000, note_q};
  assign in_legal  = (in_note <= 4'd11) && (in_index <= 7'd63);

  // Held low during reset so a producer cannot see a transfer before the block is alive
  assign in_ready = rst_n && (state_q != LOAD) && !stop;
  assign xfer     = in_valid && in_ready;

  assign rom_div      = rom_lookup(note_q);
  assign oct_max      = '1;
  assign oct_reload_d = oct_max >> oct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      oct_q        <= '0;
      note_q       <= '0;
      note_index_q <= '0;
      cnt_note_q   <= '0;
      cnt_oct_q    <= '0;
      oct_reload_q <= '0;
      speaker_q    <= 1'b0;
      playing_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= xfer && !in_legal;
      case (state_q)
        IDLE: begin
          if (xfer && in_legal) begin
            oct_q   <= in_octave;
            note_q  <= in_note;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (stop) begin
            state_q      <= IDLE;
            speaker_q    <= 1'b0;
            playing_q    <= 1'b0;
            cnt_note_q   <= '0;
            cnt_oct_q    <= '0;
            oct_reload_q <= '0;
          end else begin
            note_index_q <= cap_index[5:0];
            cnt_note_q   <= rom_div - NOTE_DIV_W'(1);
            oct_reload_q <= oct_reload_d;
            cnt_oct_q    <= oct_reload_d;
            state_q      <= PLAY;
            playing_q    <= 1'b1;
          end
        end
        PLAY: begin
          if (stop) begin
            state_q      <= IDLE;
            speaker_q    <= 1'b0;
            playing_q    <= 1'b0;
            cnt_note_q   <= '0;
            cnt_oct_q    <= '0;
            oct_reload_q <= '0;
          end else if (xfer && in_legal) begin
            // Retrigger keeps the speaker phase; only the dividers restart
            oct_q     <= in_octave;
            note_q    <= in_note;
            state_q   <= LOAD;
            playing_q <= 1'b0;
          end else if (cnt_note_q != '0) begin
            cnt_note_q <= cnt_note_q - NOTE_DIV_W'(1);
          end else begin
            cnt_note_q <= rom_div - NOTE_DIV_W'(1);
            if (cnt_oct_q == '0) begin
              cnt_oct_q <= oct_reload_q;
              speaker_q <= ~speaker_q;
            end else begin
              cnt_oct_q <= cnt_oct_q - OCT_CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_index = note_index_q;
  assign playing    = playing_q;
  assign err        = err_q;
  assign speaker    = speaker_q;

endmodule

// File: tb/tb_tone_note_player.sv
// Bench for tone_note_player: expected note indices and half-periods are queued when a note
// is sent and consumed as speaker toggles are observed.
module tb_tone_note_player;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_octave = '0;
  logic [3:0] in_note = '0;
  logic       stop = 1'b0;
  logic [5:0] note_index;
  logic       playing;
  logic       err;
  logic       speaker;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int rom_tbl[12] = '{512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271};

  always #5 clk = ~clk;

  tone_note_player dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_octave  (in_octave),
    .in_note    (in_note),
    .stop       (stop),
    .note_index (note_index),
    .playing    (playing),
    .err        (err),
    .speaker    (speaker)
  );

  function automatic int half_period(input int oct, input int note);
    return rom_tbl[note] * (256 >> oct);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int oct, input int note);
    in_octave = 3'(oct);
    in_note   = 4'(note);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  // Cycles until the speaker changes, or -1 if the budget runs out
  task automatic measure_toggle(input int budget, output int n);
    logic prev;
    bit   done;
    prev = speaker;
    done = 0;
    n    = -1;
    for (int i = 1; i <= budget && !done; i++) begin
      step();
      if (speaker !== prev) begin
        n    = i;
        done = 1;
      end
    end
  endtask

  task automatic sb_pop_toggle(input string name);
    int exp_hp;
    int n;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_hp = exp_q.pop_front();
      measure_toggle(exp_hp + 64, n);
      checks++;
      if (n !== exp_hp) begin
        errors++;
        $display("FAIL %s: toggle after %0d cycles (-1 = timeout), expected %0d", name, n, exp_hp);
      end
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (playing !== 1'b0 || speaker !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: playing=%b speaker=%b, expected 0 0", playing, speaker);
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_octave = 3'd5;
    in_note   = 4'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || speaker !== 1'b0 || note_index !== 6'd0 || playing !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals: ready=%b spk=%b idx=%0d play=%b err=%b, expected all 0",
                 in_ready, speaker, note_index, playing, err);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_accept: ready=%b playing=%b, expected 0 0 (LOAD)", in_ready, playing);
    end
    step();
    checks++;
    if (playing !== 1'b1 || note_index !== 6'd60) begin
      errors++;
      $display("FAIL reset_first_play: playing=%b idx=%0d, expected 1 60", playing, note_index);
    end
    do_stop();
  endtask

  task automatic test_oct5_note0();
    send(5, 0);
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL o5n0_load: playing=%b, expected 0 one cycle after transfer", playing);
    end
    step();
    checks++;
    if (playing !== 1'b1 || note_index !== 6'(5 * 12 + 0)) begin
      errors++;
      $display("FAIL o5n0_play: playing=%b idx=%0d, expected 1 %0d", playing, note_index, 5 * 12);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(half_period(5, 0));
    for (int i = 0; i < 3; i++) sb_pop_toggle("o5n0_half_period");
    do_stop();
  endtask

  task automatic test_oct5_limits();
    int n;
    send(5, 3);
    step();
    checks++;
    if (note_index !== 6'(5 * 12 + 3)) begin
      errors++;
      $display("FAIL o5n3_index: idx=%0d, expected %0d", note_index, 5 * 12 + 3);
    end
    exp_q.push_back(half_period(5, 3));
    sb_pop_toggle("o5n3_half_period");
    send(5, 4);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL o5n4_err: err=%b, expected 1", err);
    end
    step();
    checks++;
    if (err !== 1'b0 || note_index !== 6'd63 || playing !== 1'b1) begin
      errors++;
      $display("FAIL o5n4_after: err=%b idx=%0d playing=%b, expected 0 63 1", err, note_index, playing);
    end
    measure_toggle(half_period(5, 3) + 64, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL o5n4_partial: no toggle within budget, expected one");
    end
    exp_q.push_back(half_period(5, 3));
    sb_pop_toggle("o5n4_period_kept");
    do_stop();
  endtask

  task automatic test_illegal_idle();
    send(2, 12);
    checks++;
    if (err !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL o2n12_err: err=%b playing=%b, expected 1 0", err, playing);
    end
    send(7, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL o7n0_err: err=%b, expected 1", err);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (err !== 1'b0 || playing !== 1'b0 || in_ready !== 1'b1 || note_index !== 6'd63) begin
        errors++;
        $display("FAIL illegal_idle_hold: err=%b playing=%b ready=%b idx=%0d, expected 0 0 1 63",
                 err, playing, in_ready, note_index);
      end
    end
  endtask

  task automatic test_stop();
    send(4, 11);
    step();
    checks++;
    if (note_index !== 6'(4 * 12 + 11)) begin
      errors++;
      $display("FAIL o4n11_index: idx=%0d, expected %0d", note_index, 4 * 12 + 11);
    end
    exp_q.push_back(half_period(4, 11));
    sb_pop_toggle("o4n11_half_period");
    stop      = 1'b1;
    in_valid  = 1'b1;
    in_octave = 3'd3;
    in_note   = 4'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stop_ready: in_ready=%b, expected 0", in_ready);
    end
    step();
    stop     = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (playing !== 1'b0 || speaker !== 1'b0 || note_index !== 6'd59 || err !== 1'b0) begin
      errors++;
      $display("FAIL stop_result: playing=%b spk=%b idx=%0d err=%b, expected 0 0 59 0",
               playing, speaker, note_index, err);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (playing !== 1'b0) begin
        errors++;
        $display("FAIL stop_no_xfer: playing=%b, expected 0", playing);
      end
    end
  endtask

  task automatic test_retrigger();
    send(5, 0);
    step();
    exp_q.push_back(half_period(5, 0));
    sb_pop_toggle("retrig_first");
    send(4, 2);
    checks++;
    if (in_ready !== 1'b0 || speaker !== 1'b1 || playing !== 1'b0) begin
      errors++;
      $display("FAIL retrig_load: ready=%b spk=%b playing=%b, expected 0 1 0", in_ready, speaker, playing);
    end
    step();
    checks++;
    if (note_index !== 6'(4 * 12 + 2) || playing !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL retrig_play: idx=%0d playing=%b ready=%b, expected %0d 1 1",
               note_index, playing, in_ready, 4 * 12 + 2);
    end
    exp_q.push_back(half_period(4, 2));
    exp_q.push_back(half_period(4, 2));
    sb_pop_toggle("retrig_half_1");
    sb_pop_toggle("retrig_half_2");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (playing !== 1'b0 || note_index !== 6'd0 || speaker !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: playing=%b idx=%0d spk=%b ready=%b, expected 0 0 0 0",
               playing, note_index, speaker, in_ready);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_oct5_note0();
    test_oct5_limits();
    test_illegal_idle();
    test_stop();
    test_retrigger();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
